// File: rtl/pool_window_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pool_window_gen_if
//  Description : Stream bundle between a row-major pixel source, the 2x2
//                window generator and the downstream maxpool stage.
//                DATA_W must match the DATA_W of the attached generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pool_window_gen_if #(
    parameter int DATA_W = 12
);
    // pixel source side
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    // maxpool side (no backpressure)
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              end_data;
    logic              frame_done;

    // generator view
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output data_out,
        output out_valid,
        output end_data,
        output frame_done
    );

    // source / sink view
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  data_out,
        input  out_valid,
        input  end_data,
        input  frame_done
    );
endinterface
`default_nettype wire

// File: rtl/pool_window_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pool_window_gen
//  Description : Re-orders a row-major feature-map stream into non-overlapping
//                2x2 windows (TL, TR, BL, BR) for the maxpool stage. One even
//                row is held in a line buffer; input is stalled while a window
//                drains because the maxpool side cannot backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_window_gen #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst,      // asynchronous, active-low
    pool_window_gen_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
        $error("pool_window_gen: IMG_W (%0d) must be even and >= 2", IMG_W);
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
        $error("pool_window_gen: IMG_H (%0d) must be even and >= 2", IMG_H);
    end

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    localparam logic [2:0] S_EVEN = 3'd0;   // filling the line buffer
    localparam logic [2:0] S_ODD0 = 3'd1;   // waiting for bottom-left
    localparam logic [2:0] S_ODD1 = 3'd2;   // waiting for bottom-right
    localparam logic [2:0] S_EM0  = 3'd3;   // emitting top-left
    localparam logic [2:0] S_EM1  = 3'd4;   // emitting top-right
    localparam logic [2:0] S_EM2  = 3'd5;   // emitting bottom-left
    localparam logic [2:0] S_EM3  = 3'd6;   // emitting bottom-right

    logic [2:0]        state_q,      state_d;
    logic [COL_W-1:0]  col_q,        col_d;
    logic [ROW_W-1:0]  row_q,        row_d;
    logic [DATA_W-1:0] bl_q,         bl_d;
    logic [DATA_W-1:0] br_q,         br_d;
    logic              in_ready_q,   in_ready_d;
    logic              out_valid_q,  out_valid_d;
    logic              end_data_q,   end_data_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] data_out_q,   data_out_d;

    // Line buffer holds the even (top) row; contents survive reset on purpose.
    logic [DATA_W-1:0] lbuf_q [IMG_W];
    logic              lbuf_we;
    logic              xfer;

    // in_ready is registered, so it already reflects the current state.
    assign xfer = bus.in_valid & in_ready_q;

    // Window-order state machine and row/column pointers.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        bl_d    = bl_q;
        br_d    = br_q;
        lbuf_we = 1'b0;
        case (state_q)
            S_EVEN: begin
                if (xfer) begin
                    lbuf_we = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        row_d   = row_q + 1'b1;
                        state_d = S_ODD0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_ODD0: begin
                // col moves onto the top-right column of this window here,
                // so during emission lbuf[col-1]/lbuf[col] are the top pair.
                if (xfer) begin
                    bl_d    = bus.in_data;
                    col_d   = col_q + 1'b1;
                    state_d = S_ODD1;
                end
            end
            S_ODD1: begin
                if (xfer) begin
                    br_d    = bus.in_data;
                    state_d = S_EM0;
                end
            end
            S_EM0: state_d = S_EM1;
            S_EM1: state_d = S_EM2;
            S_EM2: state_d = S_EM3;
            S_EM3: begin
                // col+1 < IMG_W is equivalent to col not being the last column
                if (col_q != COL_LAST) begin
                    col_d   = col_q + 1'b1;
                    state_d = S_ODD0;
                end else begin
                    col_d   = '0;
                    row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    state_d = S_EVEN;
                end
            end
            default: state_d = S_EVEN;
        endcase
    end

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        in_ready_d   = (state_d == S_EVEN) || (state_d == S_ODD0) ||
                       (state_d == S_ODD1);
        out_valid_d  = (state_d == S_EM0) || (state_d == S_EM1) ||
                       (state_d == S_EM2) || (state_d == S_EM3);
        end_data_d   = (state_d == S_EM3);
        frame_done_d = (state_d == S_EM3) && (row_q == ROW_LAST) &&
                       (col_q == COL_LAST);
        data_out_d   = data_out_q;
        case (state_d)
            S_EM0:   data_out_d = lbuf_q[col_q - 1'b1];
            S_EM1:   data_out_d = lbuf_q[col_q];
            S_EM2:   data_out_d = bl_q;
            S_EM3:   data_out_d = br_q;
            default: data_out_d = data_out_q;
        endcase
    end

    // Control and output flops; reset drops any partial window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_EVEN;
            col_q        <= '0;
            row_q        <= '0;
            bl_q         <= '0;
            br_q         <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            end_data_q   <= 1'b0;
            frame_done_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            bl_q         <= bl_d;
            br_q         <= br_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            end_data_q   <= end_data_d;
            frame_done_q <= frame_done_d;
            data_out_q   <= data_out_d;
        end
    end

    // Line buffer write of the even row, no reset needed.
    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            lbuf_q[col_q] <= bus.in_data;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.end_data   = end_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.data_out   = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_window_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pool_window_gen
//  Description : Self-checking bench for pool_window_gen on a 4x4 frame.
//                Expected window words are queued when a frame is driven and
//                popped by a monitor as the generator emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_window_gen;

    localparam int DW  = 12;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int NPX = W * H;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pool_window_gen_if #(.DATA_W(DW)) bus ();

    pool_window_gen #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          ed;
        logic          fd;
    } exp_t;

    typedef struct {
        logic [DW-1:0] in_px   [NPX];
        logic [DW-1:0] exp_out [NPX];
        int            gap_pct;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[3];

    int checks       = 0;
    int failures     = 0;
    int cyc          = 0;
    int fd_count     = 0;
    int last_fd_cyc  = 0;
    bit fd_seen      = 1'b0;
    int gap_after_fd = -1;
    int burst        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every emitted word.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                burst = 0;
            end else if (bus.out_valid) begin
                burst++;
                if (fd_seen) begin
                    gap_after_fd = cyc - last_fd_cyc;
                    fd_seen      = 1'b0;
                end
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=0x%0h required=none cycle=%0d",
                             bus.data_out, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("data_out",   bus.data_out,   e.d);
                    chk("end_data",   bus.end_data,   e.ed);
                    chk("frame_done", bus.frame_done, e.fd);
                end
                if (bus.frame_done) begin
                    fd_count++;
                    last_fd_cyc = cyc;
                    fd_seen     = 1'b1;
                end
            end else begin
                if (burst != 0) chk("burst_len", burst, 4);
                burst = 0;
                if (bus.end_data || bus.frame_done) begin
                    checks++;
                    failures++;
                    $display("FAIL stray_flag actual=ed%0b/fd%0b required=0/0 cycle=%0d",
                             bus.end_data, bus.frame_done, cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input int v);
        exp_t e;
        for (int i = 0; i < NPX; i++) begin
            e.d  = vecs[v].exp_out[i];
            e.ed = ((i % 4) == 3);
            e.fd = (i == NPX - 1);
            sb.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word transferred.
    task automatic send(input logic [DW-1:0] d, input int gap_pct);
        int waitc;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        waitc = 0;
        while (!bus.in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) chk("send_timeout", waitc, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int v);
        for (int i = 0; i < NPX; i++) send(vecs[v].in_px[i], vecs[v].gap_pct);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin : main
        int fd0;
        int idx;
        int stall;
        int guard;

        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        for (int i = 0; i < NPX; i++) vecs[0].in_px[i] = DW'(i + 1);
        vecs[0].exp_out = '{12'h001, 12'h002, 12'h005, 12'h006,
                            12'h003, 12'h004, 12'h007, 12'h008,
                            12'h009, 12'h00A, 12'h00D, 12'h00E,
                            12'h00B, 12'h00C, 12'h00F, 12'h010};
        vecs[0].gap_pct = 0;
        vecs[1]         = vecs[0];
        vecs[1].gap_pct = 50;
        vecs[2].in_px   = '{12'h7FF, 12'h800, 12'h000, 12'hFFF,
                            12'h700, 12'h001, 12'h800, 12'h7FF,
                            12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD,
                            12'h0EE, 12'h0FF, 12'hF00, 12'hF11};
        vecs[2].exp_out = '{12'h7FF, 12'h800, 12'h700, 12'h001,
                            12'h000, 12'hFFF, 12'h800, 12'h7FF,
                            12'h0AA, 12'h0BB, 12'h0EE, 12'h0FF,
                            12'h0CC, 12'h0DD, 12'hF00, 12'hF11};
        vecs[2].gap_pct = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid",  bus.out_valid,  0);
        chk("rst_data_out",   bus.data_out,   0);
        chk("rst_end_data",   bus.end_data,   0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_in_ready",   bus.in_ready,   0);
        rst = 1'b1;
        #1 chk("ready_before_first_edge", bus.in_ready, 0);
        @(negedge clk);
        chk("ready_after_reset", bus.in_ready, 1);

        // Table: plain frame, gapped frame, boundary data
        for (int v = 0; v < 3; v++) begin
            fd0 = fd_count;
            push_exp(v);
            send_frame(v);
            drain("table_drain");
            chk("table_frame_done_count", fd_count - fd0, 1);
        end

        // in_ready stall pattern against a small model
        push_exp(0);
        idx   = 0;
        stall = 0;
        guard = 0;
        while ((idx < NPX || stall > 0) && guard < 200) begin
            chk("in_ready_pattern", bus.in_ready, (stall == 0));
            if (stall > 0) stall--;
            if (bus.in_ready && idx < NPX) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vecs[0].in_px[idx];
                if (((idx / W) % 2 == 1) && ((idx % W) % 2 == 1)) stall = 4;
                idx++;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("ready_seq_pixels", idx, NPX);
        drain("ready_seq_drain");

        // Reset during S_EM1 of the first row-1 window
        begin
            exp_t e;
            e.d  = 12'h001;
            e.ed = 1'b0;
            e.fd = 1'b0;
            sb.push_back(e);
        end
        for (int i = 0; i < 6; i++) send(vecs[0].in_px[i], 0);
        @(posedge clk);
        #1 chk("em1_word_before_reset", bus.data_out, 12'h002);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_out_valid",  bus.out_valid,  0);
        chk("async_rst_data_out",   bus.data_out,   0);
        chk("async_rst_end_data",   bus.end_data,   0);
        chk("async_rst_frame_done", bus.frame_done, 0);
        chk("async_rst_in_ready",   bus.in_ready,   0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drain("midreset_drain");
        chk("ready_after_midreset", bus.in_ready, 1);
        fd0 = fd_count;
        push_exp(0);
        send_frame(0);
        drain("resend_drain");
        chk("resend_frame_done_count", fd_count - fd0, 1);

        // Two back-to-back frames
        fd0 = fd_count;
        push_exp(0);
        push_exp(0);
        send_frame(0);
        send_frame(0);
        drain("b2b_drain");
        chk("b2b_frame_done_count", fd_count - fd0, 2);
        chk("b2b_fd_to_next_window_cycles", gap_after_fd, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
